// File: rtl/threshold_filter_stream_if.sv
// Valid/ready stream bundle used for both the sample input and the filtered output.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface threshold_filter_stream_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/threshold_filter_stream.sv
// Streaming threshold filter: one result stage register feeding a DEPTH-entry FIFO,
// with three compare modes and saturating pass/drop statistics.
module threshold_filter_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           threshold,
    threshold_filter_stream_if.slave   in_s,
    threshold_filter_stream_if.master  out_s,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           pass_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_DROP  = 2'd1,
        MODE_CLAMP = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    mode_t            mode_sel;
    logic             accept;
    logic             hit;
    logic             pop;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;

    logic             s_valid;
    logic [WIDTH-1:0] s_data;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign mode_sel = mode_t'(mode);

    // Ready counts the in-flight stage entry so a stage write can never find the FIFO full.
    assign in_s.ready  = (fifo_count + CW'(s_valid)) < CW'(DEPTH);
    assign accept      = in_s.valid && in_s.ready;
    assign hit         = in_s.data > threshold;
    assign out_s.valid = (fifo_count != '0);
    assign out_s.data  = out_s.valid ? mem[rd_ptr] : '0;
    assign pop         = out_s.valid && out_s.ready;

    always_comb begin
        res_valid = 1'b1;
        res_data  = '0;
        case (mode_sel)
            MODE_DROP: begin
                res_valid = hit;
                res_data  = in_s.data;
            end
            MODE_CLAMP: res_data = hit ? threshold : in_s.data;
            default:    res_data = hit ? in_s.data : '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= accept && res_valid;
            if (accept) begin
                s_data <= res_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (s_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({s_valid, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            if (accept && hit && (pass_count != '1)) begin
                pass_count <= pass_count + 1'b1;
            end
            if (accept && !hit && (mode_sel == MODE_DROP) && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_threshold_filter_stream.sv
// Randomised and directed bench for threshold_filter_stream, checked against a
// queue-based model of the output stream, occupancy and statistics.
module tb_threshold_filter_stream;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] threshold = 8'h00;
    logic [2:0] fifo_count;
    logic [3:0] pass_count;
    logic [3:0] drop_count;

    threshold_filter_stream_if #(.WIDTH(WIDTH)) in_s ();
    threshold_filter_stream_if #(.WIDTH(WIDTH)) out_s ();

    threshold_filter_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .threshold  (threshold),
        .in_s       (in_s),
        .out_s      (out_s),
        .fifo_count (fifo_count),
        .pass_count (pass_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Model: FIFO contents as a queue, plus the result accepted on the last edge.
    logic [7:0] mq[$];
    bit         pend_v;
    logic [7:0] pend_d;
    int         m_pass;
    int         m_drop;
    logic [7:0] dut_log[$];
    int         total = 0;
    int         bad = 0;

    function automatic logic [20:0] model_obs();
        int n = mq.size();
        logic rdy = (n + int'(pend_v)) < DEPTH;
        return {rdy, n != 0, (n != 0) ? mq[0] : 8'h00, 3'(n), 4'(m_pass), 4'(m_drop)};
    endfunction

    function automatic logic [20:0] dut_obs();
        return {in_s.ready, out_s.valid, out_s.data, fifo_count, pass_count, drop_count};
    endfunction

    task automatic model_reset();
        mq.delete();
        pend_v = 1'b0;
        pend_d = 8'h00;
        m_pass = 0;
        m_drop = 0;
    endtask

    task automatic drive_cycle(input bit v, input logic [7:0] d, input logic [1:0] m,
                               input logic [7:0] t, input bit ordy, output bit accepted);
        int n;
        bit rdy;
        bit pop;
        bit hit;
        in_s.valid  = v;
        in_s.data   = d;
        mode        = m;
        threshold   = t;
        out_s.ready = ordy;
        accepted = v && in_s.ready;
        if (out_s.valid && ordy) dut_log.push_back(out_s.data);
        n   = mq.size();
        rdy = (n + int'(pend_v)) < DEPTH;
        pop = (n != 0) && ordy;
        hit = d > t;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (pend_v) mq.push_back(pend_d);
        pend_v = 1'b0;
        if (v && rdy) begin
            case (m)
                2'd1: begin
                    pend_v = hit;
                    pend_d = d;
                    if (!hit && m_drop < SAT) m_drop++;
                end
                2'd2: begin
                    pend_v = 1'b1;
                    pend_d = hit ? t : d;
                end
                default: begin
                    pend_v = 1'b1;
                    pend_d = hit ? d : 8'h00;
                end
            endcase
            if (hit && m_pass < SAT) m_pass++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        in_s.valid = 1'b0;
        out_s.ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (dut_obs() !== 21'h100000) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", dut_obs(), 21'h100000);
        end
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        total++;
        if (dut_obs() !== model_obs()) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_zero();
        logic [7:0] beats[4] = '{8'h81, 8'h80, 8'hFF, 8'h00};
        logic [31:0] got = 0;
        int idx = 0;
        int first_acc = -1;
        int first_val = -1;
        bit acc;
        do_reset();
        dut_log.delete();
        for (int c = 0; c < 20; c++) begin
            drive_cycle(idx < 4, (idx < 4) ? beats[idx] : 8'h00, 2'd0, 8'h80, 1'b1, acc);
            if (acc && first_acc < 0) first_acc = c;
            if (acc) idx++;
            if (out_s.valid && first_val < 0) first_val = c;
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL zero_cycle c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        foreach (dut_log[i]) got = {got[23:0], dut_log[i]};
        total++;
        if (dut_log.size() != 4 || got !== 32'h8100FF00) begin
            bad++;
            $display("FAIL zero_stream n=%0d got=%h exp=8100ff00", dut_log.size(), got);
        end
        total++;
        if (first_val - first_acc != 1) begin
            bad++;
            $display("FAIL zero_latency acc=%0d valid=%0d", first_acc, first_val);
        end
        total++;
        if (pass_count !== 4'd2 || drop_count !== 4'd0) begin
            bad++;
            $display("FAIL zero_counts got=%0d/%0d exp=2/0", pass_count, drop_count);
        end
    endtask

    task automatic test_drop();
        logic [7:0] beats[4] = '{8'h81, 8'h80, 8'hFF, 8'h00};
        logic [15:0] got = 0;
        int idx = 0;
        int peak = 0;
        bit acc;
        do_reset();
        dut_log.delete();
        for (int c = 0; c < 16; c++) begin
            drive_cycle(idx < 4, (idx < 4) ? beats[idx] : 8'h00, 2'd1, 8'h80, c >= 6, acc);
            if (acc) idx++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL drop_cycle c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        foreach (dut_log[i]) got = {got[7:0], dut_log[i]};
        total++;
        if (dut_log.size() != 2 || got !== 16'h81FF || peak != 2) begin
            bad++;
            $display("FAIL drop_stream n=%0d got=%h peak=%0d exp=81ff peak 2", dut_log.size(), got, peak);
        end
        total++;
        if (pass_count !== 4'd2 || drop_count !== 4'd2) begin
            bad++;
            $display("FAIL drop_counts got=%0d/%0d exp=2/2", pass_count, drop_count);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp_seq[$];
        int accepts = 0;
        bit acc;
        logic [7:0] d;
        dut_log.delete();
        for (int c = 0; c < 8; c++) begin
            d = 8'($urandom);
            drive_cycle(1'b1, d, 2'd0, 8'h40, 1'b0, acc);
            if (acc) begin
                accepts++;
                exp_seq.push_back((d > 8'h40) ? d : 8'h00);
            end
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL bp_fill c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        total++;
        if (accepts != DEPTH || in_s.ready !== 1'b0 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL bp_full accepts=%0d ready=%b count=%0d exp=4/0/4", accepts, in_s.ready, fifo_count);
        end
        for (int c = 0; c < 8; c++) begin
            drive_cycle(1'b0, 8'h00, 2'd0, 8'h40, 1'b1, acc);
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL bp_drain c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        total++;
        if (dut_log != exp_seq) begin
            bad++;
            $display("FAIL bp_order got=%p exp=%p", dut_log, exp_seq);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] beats[4] = '{8'h10, 8'h40, 8'h41, 8'hC0};
        logic [31:0] got = 0;
        int idx = 0;
        bit acc;
        do_reset();
        dut_log.delete();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(idx < 4, (idx < 4) ? beats[idx] : 8'h00, 2'd2, 8'h40, 1'b1, acc);
            if (acc) idx++;
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL clamp_cycle c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        foreach (dut_log[i]) got = {got[23:0], dut_log[i]};
        total++;
        if (dut_log.size() != 4 || got !== 32'h10404040) begin
            bad++;
            $display("FAIL clamp_stream n=%0d got=%h exp=10404040", dut_log.size(), got);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] q_beats[3] = '{8'h50, 8'h60, 8'h05};
        logic [23:0] got = 0;
        int accepts = 0;
        int idx = 0;
        bit acc;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b1, 8'($urandom_range(1, 255)), 2'd0, 8'h00, 1'b1, acc);
            if (acc) accepts++;
        end
        total++;
        if (accepts != 20 || pass_count !== 4'hF || m_pass != SAT) begin
            bad++;
            $display("FAIL sat_pass accepts=%0d got=%h exp=20 f", accepts, pass_count);
        end
        drive_cycle(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, acc);
        drive_cycle(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, acc);
        dut_log.delete();
        for (int c = 0; c < 16; c++) begin
            if (c < 6) drive_cycle(idx < 3, (idx < 3) ? q_beats[idx] : 8'h00, 2'd2, 8'h10, 1'b0, acc);
            else drive_cycle(1'b0, 8'h33, 2'd1, 8'hFF, c >= 9, acc);
            if (acc) idx++;
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL sat_cycle c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
        foreach (dut_log[i]) got = {got[15:0], dut_log[i]};
        total++;
        if (dut_log.size() != 3 || got !== 24'h101005 || pass_count !== 4'hF) begin
            bad++;
            $display("FAIL sat_queued n=%0d got=%h pass=%h exp=101005 f", dut_log.size(), got, pass_count);
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 300; c++) begin
            drive_cycle($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 8'($urandom),
                        $urandom_range(0, 9) < 7, acc);
            total++;
            if (dut_obs() !== model_obs()) begin
                bad++;
                $display("FAIL rand_cycle c=%0d got=%h exp=%h", c, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        for (int c = 0; c < 3; c++) drive_cycle(1'b1, 8'hA5, 2'd0, 8'h10, 1'b0, acc);
        total++;
        if (fifo_count !== 3'(mq.size()) || fifo_count === 3'd0) begin
            bad++;
            $display("FAIL mid_prefill got=%0d exp=%0d", fifo_count, mq.size());
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (dut_obs() !== 21'h100000) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", dut_obs(), 21'h100000);
        end
        model_reset();
        in_s.valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_cycle(1'b0, 8'h00, 2'd0, 8'h00, 1'b1, acc);
        total++;
        if (dut_obs() !== model_obs()) begin
            bad++;
            $display("FAIL mid_after got=%h exp=%h", dut_obs(), model_obs());
        end
    endtask

    initial begin
        in_s.valid  = 1'b0;
        in_s.data   = 8'h00;
        out_s.ready = 1'b0;
        model_reset();
        test_reset();
        test_zero();
        test_drop();
        test_back_pressure();
        test_clamp();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
